uart_tx_debug: RTL and testbench
================================

Name: uart_tx_debug

Overview:
- Serial transmitter driving the top-level `tx` pin of the debug link; it is the transmit end of the link whose receive end is `rx`.
- Accepts bytes from the debug/dump logic through a valid/ready handshake and buffers them in a small FIFO.
- Serialises each byte as 8N1 UART frames: 1 start bit, 8 data bits LSB first, no parity, 1 stop bit.
- Runs entirely in the `clk` domain, with an internal baud divider.

Parameters:
- CLK_DIV, 434, clock cycles per serial bit (50 MHz / 115200); legal range 2..65535.
- FIFO_DEPTH, 4, byte entries in the input FIFO; must be a power of two, 2..16.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  reset; synchronous, active-low (0 = reset).
- tx_data  in  8  byte to send; sampled when tx_valid && tx_ready.
- tx_valid  in  1  producer has a byte on tx_data.
- tx_ready  out  1  FIFO can accept a byte; equals !full.
- tx  out  1  serial line, registered; idles high.
- busy  out  1  high while the FIFO is non-empty or a frame is in progress.
- fifo_count  out  clog2(FIFO_DEPTH)+1  number of bytes currently held in the FIFO.

Behaviour:
- Reset (reset=0 at an edge):
  - tx=1, state=IDLE, FIFO emptied, fifo_count=0, tx_ready=1, busy=0.
  - Baud and bit counters cleared.
  - Reset mid-frame aborts the frame: tx is 1 from the next edge and any buffered bytes are discarded.
- FIFO:
  - Push on an edge where tx_valid && tx_ready.
  - Pop only when the FSM loads the shift register.
  - Push and pop in the same edge: fifo_count unchanged, order preserved.
  - tx_valid while full (tx_ready=0): ignored, no overwrite. The producer must hold data until ready.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If the FIFO is non-empty at an edge: pop into the 8-bit shift register, tx<=0, baud_cnt<=0, go to START.
  - START: hold tx=0 for CLK_DIV cycles. When baud_cnt==CLK_DIV-1: tx<=shift[0], bit_cnt<=0, go to DATA.
  - DATA: each bit lasts CLK_DIV cycles. At the end of a bit: shift right, and either drive the next bit or, after bit_cnt==7, tx<=1 and go to STOP.
  - STOP: hold tx=1 for CLK_DIV cycles. At the end, if the FIFO is non-empty, pop and enter START directly: back-to-back frames, no idle gap. Otherwise go to IDLE.
- Timing:
  - A byte pushed at edge N into an empty, idle block drives tx low from edge N+1.
  - The frame occupies exactly 10*CLK_DIV cycles.
  - The stop bit ends at edge N+1+10*CLK_DIV.
- Counter widths:
  - baud_cnt is wide enough for CLK_DIV-1 and resets to 0 at each bit boundary.
  - bit_cnt is 3 bits.
- busy = (state != IDLE) || (fifo_count != 0). It is deasserted the cycle after the final stop bit completes with the FIFO empty.
- tx_data is captured at push time; later changes on tx_data do not affect a queued byte.

Test Plan (CLK_DIV=4, FIFO_DEPTH=4):
- Reset then idle 50 cycles -> tx=1, tx_ready=1, busy=0, fifo_count=0 throughout.
- Push 0x55 once.
  - tx low exactly 1 edge after the push.
  - Line sequence, each bit 4 cycles: 0,1,0,1,0,1,0,1,0,1.
  - busy falls after 40 cycles; decoded byte = 0x55.
- Push 0xA3, 0x0F back-to-back.
  - Two frames with no idle cycle between stop and start.
  - Decoded 0xA3 then 0x0F; total 80 cycles.
- Push 6 bytes with tx_valid held continuously.
  - tx_ready drops when fifo_count=4 while the first frame is in flight.
  - No byte lost or duplicated; output order matches input order.
- Assert reset=0 for 1 cycle during the 4th data bit of 0xFF with 2 bytes queued.
  - tx=1 next edge, fifo_count=0, busy=0.
  - No further frames are sent.
- Simultaneous push and pop at fifo_count=2 (push on the same edge as a STOP->START transition) -> fifo_count stays 2, order preserved.

Source files
------------

// File: rtl/uart_tx_debug.sv
// Debug-link UART transmitter: small byte FIFO feeding an 8N1 serialiser.
// One start bit, eight data bits LSB first, one stop bit, CLK_DIV clocks per bit.
module uart_tx_debug #(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST  = BW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state_r;
  logic [7:0]      mem_r [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic [BW-1:0]   baud_cnt_r;
  logic [2:0]      bit_cnt_r;
  logic [7:0]      shift_r;
  logic            tx_r;

  logic            full_s;
  logic            empty_s;
  logic            push_s;
  logic            pop_s;
  logic            baud_end_s;

  assign full_s     = (count_r == FULL_COUNT);
  assign empty_s    = (count_r == {CW{1'b0}});
  assign baud_end_s = (baud_cnt_r == BAUD_LAST);
  assign push_s     = tx_valid && !full_s;
  // The FIFO is drained only when the serialiser loads a new frame.
  assign pop_s      = !empty_s && ((state_r == IDLE) || ((state_r == STOP) && baud_end_s));

  // Byte storage, written at push time so later tx_data changes cannot leak in
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= tx_data;
    end
  end

  // FIFO pointers and occupancy count
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Frame sequencer: baud timing, bit counting and the registered line driver
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= IDLE;
      tx_r       <= 1'b1;
      baud_cnt_r <= {BW{1'b0}};
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'h00;
    end else begin
      case (state_r)
        IDLE: begin
          tx_r <= 1'b1;
          if (pop_s) begin
            shift_r    <= mem_r[rd_ptr_r];
            tx_r       <= 1'b0;
            baud_cnt_r <= {BW{1'b0}};
            state_r    <= START;
          end
        end
        START: begin
          if (baud_end_s) begin
            tx_r       <= shift_r[0];
            bit_cnt_r  <= 3'd0;
            baud_cnt_r <= {BW{1'b0}};
            state_r    <= DATA;
          end else begin
            baud_cnt_r <= baud_cnt_r + BW'(1);
          end
        end
        DATA: begin
          if (baud_end_s) begin
            baud_cnt_r <= {BW{1'b0}};
            if (bit_cnt_r == 3'd7) begin
              tx_r    <= 1'b1;
              state_r <= STOP;
            end else begin
              tx_r      <= shift_r[1];
              shift_r   <= {1'b0, shift_r[7:1]};
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + BW'(1);
          end
        end
        STOP: begin
          if (baud_end_s) begin
            baud_cnt_r <= {BW{1'b0}};
            // Chain straight into the next start bit when more bytes wait.
            if (pop_s) begin
              shift_r <= mem_r[rd_ptr_r];
              tx_r    <= 1'b0;
              state_r <= START;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + BW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          tx_r    <= 1'b1;
        end
      endcase
    end
  end

  assign tx         = tx_r;
  assign tx_ready   = !full_s;
  assign busy       = (state_r != IDLE) || !empty_s;
  assign fifo_count = count_r;

endmodule

// File: tb/tb_uart_tx_debug.sv
// Directed bench for uart_tx_debug (CLK_DIV=4, FIFO_DEPTH=4): a line monitor
// decodes every frame and checks it against a queue of expected bytes.
module tb_uart_tx_debug;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  int start_q[$];
  logic [7:0] six_b [6];

  uart_tx_debug #(.CLK_DIV(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      step();
      n++;
    end
    check(tag, {39'd0, busy}, 40'd0);
  endtask

  // Line monitor: captures 40 samples per frame, aborts the frame on reset
  initial begin : monitor
    logic [39:0] act_line;
    logic [39:0] exp_line;
    logic [7:0]  exp_byte;
    logic [7:0]  dec;
    logic        aborted;
    logic        have_exp;
    forever begin
      @(negedge clk);
      if (tx === 1'b0 && reset === 1'b1) begin
        start_q.push_back(cyc);
        have_exp = (exp_q.size() != 0);
        check("sb_has_byte", {39'd0, have_exp}, 40'd1);
        exp_byte = 8'h00;
        if (have_exp) exp_byte = exp_q.pop_front();
        act_line = 40'd0;
        act_line[0] = tx;
        aborted = 1'b0;
        for (int j = 1; j < 40; j++) begin
          @(negedge clk);
          if (reset !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          act_line[j] = tx;
        end
        if (!aborted && have_exp) begin
          for (int j = 0; j < 40; j++) begin
            if (j < 4) exp_line[j] = 1'b0;
            else if (j >= 36) exp_line[j] = 1'b1;
            else exp_line[j] = exp_byte[(j / 4) - 1];
          end
          check("frame_line", act_line, exp_line);
          for (int b = 0; b < 8; b++) dec[b] = act_line[4 * (b + 1) + 2];
          check("frame_byte", {32'd0, dec}, {32'd0, exp_byte});
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int e;
    int k;
    int i;
    int n;
    logic rdy;
    logic bad;
    logic saw_block;
    logic ready_bad;

    six_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    reset = 1'b0;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    step();
    step();
    reset = 1'b1;
    check("rst_tx", {39'd0, tx}, 40'd1);
    check("rst_ready", {39'd0, tx_ready}, 40'd1);
    check("rst_busy", {39'd0, busy}, 40'd0);
    check("rst_count", {37'd0, fifo_count}, 40'd0);

    // Idle quietly for 50 cycles
    bad = 1'b0;
    for (int c = 0; c < 50; c++) begin
      step();
      if (tx !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) bad = 1'b1;
    end
    check("idle_50", {39'd0, bad}, 40'd0);

    // Single byte 0x55
    e = cyc;
    start_q.delete();
    exp_q.push_back(8'h55);
    tx_data = 8'h55;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    tx_data = 8'hEE;
    check("one_count", {37'd0, fifo_count}, 40'd1);
    check("one_tx_hi", {39'd0, tx}, 40'd1);
    step();
    check("one_latency", {39'd0, tx}, 40'd0);
    check("one_busy", {39'd0, busy}, 40'd1);
    wait_until(e + 41);
    check("one_busy_end", {39'd0, busy}, 40'd1);
    step();
    check("one_busy_fall", {39'd0, busy}, 40'd0);
    check("one_frames", start_q.size(), 40'd1);
    if (start_q.size() >= 1) check("one_start_cyc", start_q[0], e + 2);

    // Back-to-back 0xA3, 0x0F
    e = cyc;
    start_q.delete();
    exp_q.push_back(8'hA3);
    tx_data = 8'hA3;
    tx_valid = 1'b1;
    step();
    exp_q.push_back(8'h0F);
    tx_data = 8'h0F;
    step();
    tx_valid = 1'b0;
    wait_until(e + 81);
    check("b2b_busy_end", {39'd0, busy}, 40'd1);
    step();
    check("b2b_busy_fall", {39'd0, busy}, 40'd0);
    check("b2b_frames", start_q.size(), 40'd2);
    if (start_q.size() >= 2) begin
      check("b2b_start_cyc", start_q[0], e + 2);
      check("b2b_gap", start_q[1] - start_q[0], 40'd40);
    end

    // Six bytes with tx_valid held until accepted
    i = 0;
    n = 0;
    saw_block = 1'b0;
    ready_bad = 1'b0;
    tx_valid = 1'b1;
    while (i < 6 && n < 200) begin
      tx_data = six_b[i];
      if (fifo_count === 3'd4 && tx_ready === 1'b0) saw_block = 1'b1;
      if (tx_ready !== (fifo_count != 3'd4)) ready_bad = 1'b1;
      rdy = tx_ready;
      if (rdy) exp_q.push_back(six_b[i]);
      step();
      n++;
      if (rdy) i++;
    end
    tx_valid = 1'b0;
    check("six_pushed", i, 40'd6);
    check("six_full_block", {39'd0, saw_block}, 40'd1);
    check("six_ready_eq", {39'd0, ready_bad}, 40'd0);
    wait_idle("six_drain", 400);
    check("six_sb_empty", exp_q.size(), 40'd0);

    // Push coinciding with STOP->START pop at fifo_count=2
    e = cyc;
    tx_valid = 1'b1;
    for (int b = 0; b < 3; b++) begin
      tx_data = 8'hC0 + 8'(b);
      exp_q.push_back(tx_data);
      step();
    end
    tx_valid = 1'b0;
    wait_until(e + 41);
    check("pp_count_before", {37'd0, fifo_count}, 40'd2);
    tx_data = 8'h5A;
    exp_q.push_back(8'h5A);
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    check("pp_count_after", {37'd0, fifo_count}, 40'd2);
    check("pp_new_start", {39'd0, tx}, 40'd0);
    wait_idle("pp_drain", 300);
    check("pp_sb_empty", exp_q.size(), 40'd0);

    // Reset during the 4th data bit of 0xFF with two bytes queued
    e = cyc;
    tx_valid = 1'b1;
    tx_data = 8'hFF;
    exp_q.push_back(8'hFF);
    step();
    tx_data = 8'h12;
    exp_q.push_back(8'h12);
    step();
    tx_data = 8'h34;
    exp_q.push_back(8'h34);
    step();
    tx_valid = 1'b0;
    k = e + 2;
    wait_until(k + 16);
    check("rst_mid_count", {37'd0, fifo_count}, 40'd2);
    reset = 1'b0;
    step();
    reset = 1'b1;
    exp_q.delete();
    check("rst_mid_tx", {39'd0, tx}, 40'd1);
    check("rst_mid_count0", {37'd0, fifo_count}, 40'd0);
    check("rst_mid_busy", {39'd0, busy}, 40'd0);
    check("rst_mid_ready", {39'd0, tx_ready}, 40'd1);
    bad = 1'b0;
    for (int c = 0; c < 60; c++) begin
      step();
      if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    check("rst_no_frames", {39'd0, bad}, 40'd0);
    check("final_sb_empty", exp_q.size(), 40'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
